// File: rtl/ram_arbiter.sv
// Two-master arbiter sharing one RAM request/ack channel between the
// instruction-fetch port and the data port, with AMO lock support.
module ram_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // instruction port
  input  logic        ins_stb_i,
  input  logic [31:0] ins_addr_i,
  output logic        ins_ack_o,
  output logic [31:0] ins_data_o,
  // data port
  input  logic        data_stb_i,
  input  logic [3:0]  data_sel_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [2:0]  data_addr_tag_i,
  input  logic [31:0] data_data_i,
  output logic        data_ack_o,
  output logic [31:0] data_data_o,
  output logic        data_data_tag_o,
  // RAM bus
  output logic        stb_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [2:0]  addr_tag_o,
  output logic [31:0] data_o,
  input  logic        ack_i,
  input  logic [31:0] data_i,
  input  logic        data_tag_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_INS,
    BUSY_DATA
  } state_t;

  // Tag layout: [2:1] mode, [0] lock/unlock
  localparam logic [1:0] MODE_AMO   = 2'b10;
  localparam logic       TAG_LOCK   = 1'b1;
  localparam logic       TAG_UNLOCK = 1'b0;

  localparam logic GRANT_INS  = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  state_t state_reg;
  state_t state_next;
  logic   last_grant_reg;
  logic   amo_lock_reg;
  logic   grant_ins;
  logic   grant_data;
  logic   ins_eligible;
  logic   lock_done;
  logic   unlock_done;

  // While an AMO lock is held, only the data port may be granted.
  assign ins_eligible = ins_stb_i && !amo_lock_reg;

  // Lock bookkeeping keys off the latched request, which is what the RAM
  // just completed.
  assign lock_done   = (addr_tag_o[2:1] == MODE_AMO) && (addr_tag_o[0] == TAG_LOCK)
                       && !we_o;
  assign unlock_done = (addr_tag_o[2:1] == MODE_AMO) && (addr_tag_o[0] == TAG_UNLOCK)
                       && we_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_ins  = 1'b0;
    grant_data = 1'b0;
    case (state_reg)
      IDLE: begin
        if (data_stb_i && ins_eligible) begin
          grant_data = RR_ENABLE ? (last_grant_reg == GRANT_INS) : 1'b1;
        end else begin
          grant_data = data_stb_i;
        end
        grant_ins = ins_eligible && !grant_data;
        if (grant_data) begin
          state_next = BUSY_DATA;
        end else if (grant_ins) begin
          state_next = BUSY_INS;
        end
      end
      BUSY_INS, BUSY_DATA: begin
        if (ack_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stb_o           <= 1'b0;
      sel_o           <= 4'b0000;
      we_o            <= 1'b0;
      addr_o          <= 32'h0;
      addr_tag_o      <= 3'b000;
      data_o          <= 32'h0;
      ins_ack_o       <= 1'b0;
      ins_data_o      <= 32'h0;
      data_ack_o      <= 1'b0;
      data_data_o     <= 32'h0;
      data_data_tag_o <= 1'b0;
      last_grant_reg  <= GRANT_INS;
      amo_lock_reg    <= 1'b0;
    end else begin
      ins_ack_o  <= 1'b0;
      data_ack_o <= 1'b0;

      if (grant_data) begin
        stb_o      <= 1'b1;
        sel_o      <= data_sel_i;
        we_o       <= data_we_i;
        addr_o     <= data_addr_i;
        addr_tag_o <= data_addr_tag_i;
        data_o     <= data_data_i;
      end else if (grant_ins) begin
        // Instruction fetches are always full-word reads with no tag.
        stb_o      <= 1'b1;
        sel_o      <= 4'b1111;
        we_o       <= 1'b0;
        addr_o     <= ins_addr_i;
        addr_tag_o <= 3'b000;
        data_o     <= 32'h0;
      end

      if (ack_i && (state_reg == BUSY_INS)) begin
        stb_o          <= 1'b0;
        ins_ack_o      <= 1'b1;
        ins_data_o     <= data_i;
        last_grant_reg <= GRANT_INS;
      end

      if (ack_i && (state_reg == BUSY_DATA)) begin
        stb_o           <= 1'b0;
        data_ack_o      <= 1'b1;
        data_data_o     <= data_i;
        data_data_tag_o <= data_tag_i;
        last_grant_reg  <= GRANT_DATA;
        if (lock_done) begin
          amo_lock_reg <= 1'b1;
        end else if (unlock_done) begin
          amo_lock_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table of single transactions plus
// hand sequences for AMO locking, idle acks, reset abort and fixed priority.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ins_stb;
  logic [31:0] ins_addr;
  logic        ins_ack;
  logic [31:0] ins_data;
  logic        data_stb;
  logic [3:0]  data_sel;
  logic        data_we;
  logic [31:0] data_addr;
  logic [2:0]  data_addr_tag;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        data_rtag;
  logic        stb_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [2:0]  addr_tag_o;
  logic [31:0] wdata_o;
  logic        ack_i;
  logic [31:0] data_i;
  logic        data_tag_i;

  // fixed-priority instance, both ports always requesting, zero-wait RAM
  logic        fp_one;
  logic        fp_ins_ack;
  logic [31:0] fp_ins_data;
  logic        fp_data_ack;
  logic [31:0] fp_data_data;
  logic        fp_data_tag;
  logic        fp_stb;
  logic [3:0]  fp_sel;
  logic        fp_we;
  logic [31:0] fp_addr;
  logic [2:0]  fp_addr_tag;
  logic [31:0] fp_wdata;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ins_ack_cnt = 0;
  int data_ack_cnt = 0;
  int fp_ins_cnt = 0;
  int fp_data_cnt = 0;
  logic [31:0] model_ins_data;
  logic [31:0] model_data_data;

  ram_arbiter #(.RR_ENABLE(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ins_stb_i(ins_stb), .ins_addr_i(ins_addr), .ins_ack_o(ins_ack), .ins_data_o(ins_data),
    .data_stb_i(data_stb), .data_sel_i(data_sel), .data_we_i(data_we),
    .data_addr_i(data_addr), .data_addr_tag_i(data_addr_tag), .data_data_i(data_wdata),
    .data_ack_o(data_ack), .data_data_o(data_rdata), .data_data_tag_o(data_rtag),
    .stb_o(stb_o), .sel_o(sel_o), .we_o(we_o), .addr_o(addr_o), .addr_tag_o(addr_tag_o),
    .data_o(wdata_o), .ack_i(ack_i), .data_i(data_i), .data_tag_i(data_tag_i)
  );

  ram_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .ins_stb_i(fp_one), .ins_addr_i(32'h0000_1000), .ins_ack_o(fp_ins_ack), .ins_data_o(fp_ins_data),
    .data_stb_i(fp_one), .data_sel_i(4'b1111), .data_we_i(1'b0),
    .data_addr_i(32'h0000_2000), .data_addr_tag_i(3'b000), .data_data_i(32'h0),
    .data_ack_o(fp_data_ack), .data_data_o(fp_data_data), .data_data_tag_o(fp_data_tag),
    .stb_o(fp_stb), .sel_o(fp_sel), .we_o(fp_we), .addr_o(fp_addr), .addr_tag_o(fp_addr_tag),
    .data_o(fp_wdata), .ack_i(fp_stb), .data_i(32'h1234_5678), .data_tag_i(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ins_ack)     ins_ack_cnt++;
    if (data_ack)    data_ack_cnt++;
    if (fp_ins_ack)  fp_ins_cnt++;
    if (fp_data_ack) fp_data_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        ins_stb;
    logic [31:0] ins_addr;
    logic        d_stb;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  tag;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        rtag;
    logic        exp_data;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [2:0]  exp_tag;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Drives one vector, plays the RAM with the vector's latency and checks
  // the bus request and the routed response.
  task automatic run_vec(input vec_t v, input string tag_name);
    int n;
    ins_stb       = v.ins_stb;
    ins_addr      = v.ins_addr;
    data_stb      = v.d_stb;
    data_sel      = v.sel;
    data_we       = v.we;
    data_addr     = v.addr;
    data_addr_tag = v.tag;
    data_wdata    = v.wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stb_o && n < 20);
    if (!stb_o) begin
      chk({tag_name, " request timeout"}, 32'(stb_o), 32'd1);
      return;
    end
    chk({tag_name, " req latency"}, 32'(n), 32'd1);
    chk({tag_name, " sel"}, 32'(sel_o), 32'(v.exp_sel));
    chk({tag_name, " we"}, 32'(we_o), 32'(v.exp_we));
    chk({tag_name, " addr"}, addr_o, v.exp_addr);
    chk({tag_name, " addr_tag"}, 32'(addr_tag_o), 32'(v.exp_tag));
    chk({tag_name, " wdata"}, wdata_o, v.exp_wdata);
    for (int k = 1; k < v.lat; k++) begin
      @(negedge clk);
      chk({tag_name, " stb held"}, 32'(stb_o), 32'd1);
    end
    ack_i      = 1'b1;
    data_i     = v.rdata;
    data_tag_i = v.rtag;
    @(negedge clk);
    ack_i      = 1'b0;
    data_i     = 32'h0;
    data_tag_i = 1'b0;
    if (v.exp_data) model_data_data = v.rdata;
    else            model_ins_data  = v.rdata;
    chk({tag_name, " stb dropped"}, 32'(stb_o), 32'd0);
    chk({tag_name, " ins_ack"}, 32'(ins_ack), 32'(!v.exp_data));
    chk({tag_name, " data_ack"}, 32'(data_ack), 32'(v.exp_data));
    chk({tag_name, " ins_data"}, ins_data, model_ins_data);
    chk({tag_name, " data_data"}, data_rdata, model_data_data);
    if (v.exp_data) begin
      chk({tag_name, " data_tag"}, 32'(data_rtag), 32'(v.rtag));
      data_stb = 1'b0;
    end else begin
      ins_stb = 1'b0;
    end
  endtask

  initial begin
    vec_t r;
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 4'h0, 1'b0, 32'h0,   3'b000, 32'h0,        3, 32'hDEAD_BEEF, 1'b0,
                 1'b0, 4'hF, 1'b0, 32'h100, 3'b000, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,   1'b1, 4'h1, 1'b1, 32'h203, 3'b000, 32'h0000_00A5, 2, 32'h0,        1'b0,
                 1'b1, 4'h1, 1'b1, 32'h203, 3'b000, 32'h0000_00A5};
    vecs[2]  = '{1'b1, 32'h200, 1'b1, 4'h3, 1'b0, 32'h300, 3'b010, 32'h5555_AAAA, 1, 32'h1111_1111, 1'b0,
                 1'b0, 4'hF, 1'b0, 32'h200, 3'b000, 32'h0};
    vecs[3]  = '{1'b1, 32'h204, 1'b1, 4'h3, 1'b0, 32'h300, 3'b010, 32'h5555_AAAA, 2, 32'h2222_2222, 1'b0,
                 1'b1, 4'h3, 1'b0, 32'h300, 3'b010, 32'h5555_AAAA};
    vecs[4]  = '{1'b1, 32'h204, 1'b1, 4'hF, 1'b1, 32'h304, 3'b000, 32'hCAFE_F00D, 1, 32'h3333_3333, 1'b0,
                 1'b0, 4'hF, 1'b0, 32'h204, 3'b000, 32'h0};
    vecs[5]  = '{1'b1, 32'h208, 1'b1, 4'hF, 1'b1, 32'h304, 3'b000, 32'hCAFE_F00D, 1, 32'h4444_4444, 1'b0,
                 1'b1, 4'hF, 1'b1, 32'h304, 3'b000, 32'hCAFE_F00D};
    vecs[6]  = '{1'b1, 32'h208, 1'b0, 4'h0, 1'b0, 32'h0,   3'b000, 32'h0,        1, 32'h5555_5555, 1'b0,
                 1'b0, 4'hF, 1'b0, 32'h208, 3'b000, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 4'hF, 1'b0, 32'h500, 3'b011, 32'h0,        1, 32'h6666_6666, 1'b0,
                 1'b1, 4'hF, 1'b0, 32'h500, 3'b011, 32'h0};
    vecs[8]  = '{1'b1, 32'h20C, 1'b0, 4'h0, 1'b0, 32'h0,   3'b000, 32'h0,        1, 32'h7777_7777, 1'b0,
                 1'b0, 4'hF, 1'b0, 32'h20C, 3'b000, 32'h0};
    vecs[9]  = '{1'b1, 32'h210, 1'b1, 4'hF, 1'b1, 32'h500, 3'b010, 32'h1,        2, 32'h0,         1'b1,
                 1'b1, 4'hF, 1'b1, 32'h500, 3'b010, 32'h1};
    vecs[10] = '{1'b1, 32'h210, 1'b0, 4'h0, 1'b0, 32'h0,   3'b000, 32'h0,        1, 32'h8888_8888, 1'b0,
                 1'b0, 4'hF, 1'b0, 32'h210, 3'b000, 32'h0};

    rst_n = 1'b0; fp_one = 1'b1;
    ins_stb = 1'b0; ins_addr = 32'h0; data_stb = 1'b0; data_sel = 4'h0; data_we = 1'b0;
    data_addr = 32'h0; data_addr_tag = 3'b000; data_wdata = 32'h0;
    ack_i = 1'b0; data_i = 32'h0; data_tag_i = 1'b0;
    model_ins_data = 32'h0; model_data_data = 32'h0;
    repeat (3) @(negedge clk);

    chk("reset stb_o", 32'(stb_o), 32'd0);
    chk("reset sel_o", 32'(sel_o), 32'd0);
    chk("reset we_o", 32'(we_o), 32'd0);
    chk("reset addr_o", addr_o, 32'h0);
    chk("reset addr_tag_o", 32'(addr_tag_o), 32'd0);
    chk("reset data_o", wdata_o, 32'h0);
    chk("reset ins_ack", 32'(ins_ack), 32'd0);
    chk("reset data_ack", 32'(data_ack), 32'd0);
    chk("reset ins_data", ins_data, 32'h0);
    chk("reset data_data", data_rdata, 32'h0);
    chk("reset data_tag", 32'(data_rtag), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // AMO lock read, two idle cycles (one with a stray ack), unlock write;
    // the instruction port requests throughout.
    ins_stb = 1'b1; ins_addr = 32'h300;
    data_stb = 1'b1; data_sel = 4'hF; data_we = 1'b0; data_addr = 32'h400;
    data_addr_tag = 3'b101; data_wdata = 32'h0;
    @(negedge clk);
    chk("amo lock req stb", 32'(stb_o), 32'd1);
    chk("amo lock req addr", addr_o, 32'h400);
    chk("amo lock req tag", 32'(addr_tag_o), 32'b101);
    ack_i = 1'b1; data_i = 32'hAAAA_0001;
    @(negedge clk);
    data_i = 32'hBADB_AD00;
    chk("amo lock ack", 32'(data_ack), 32'd1);
    chk("amo lock data", data_rdata, 32'hAAAA_0001);
    data_stb = 1'b0;
    @(negedge clk);
    ack_i = 1'b0; data_i = 32'h0;
    chk("idle ack no ins_ack", 32'(ins_ack), 32'd0);
    chk("idle ack no data_ack", 32'(data_ack), 32'd0);
    chk("locked idle1 stb", 32'(stb_o), 32'd0);
    chk("idle ack ins_data held", ins_data, 32'h8888_8888);
    @(negedge clk);
    chk("locked idle2 stb", 32'(stb_o), 32'd0);
    data_stb = 1'b1; data_we = 1'b1; data_addr_tag = 3'b100; data_wdata = 32'hAAAA_0002;
    @(negedge clk);
    chk("amo unlock stb", 32'(stb_o), 32'd1);
    chk("amo unlock we", 32'(we_o), 32'd1);
    chk("amo unlock tag", 32'(addr_tag_o), 32'b100);
    chk("amo unlock wdata", wdata_o, 32'hAAAA_0002);
    ack_i = 1'b1; data_i = 32'h0;
    @(negedge clk);
    ack_i = 1'b0;
    chk("amo unlock ack", 32'(data_ack), 32'd1);
    chk("amo unlock no ins_ack", 32'(ins_ack), 32'd0);
    data_stb = 1'b0;
    @(negedge clk);
    chk("post unlock ins stb", 32'(stb_o), 32'd1);
    chk("post unlock ins addr", addr_o, 32'h300);
    chk("post unlock ins sel", 32'(sel_o), 32'hF);
    ack_i = 1'b1; data_i = 32'h9999_9999;
    @(negedge clk);
    ack_i = 1'b0; data_i = 32'h0;
    chk("post unlock ins_ack", 32'(ins_ack), 32'd1);
    chk("post unlock ins_data", ins_data, 32'h9999_9999);
    ins_stb = 1'b0;
    model_ins_data = 32'h9999_9999; model_data_data = 32'h0;

    // Reset in the middle of a data transaction.
    data_stb = 1'b1; data_sel = 4'hF; data_we = 1'b0; data_addr = 32'h600;
    data_addr_tag = 3'b000; data_wdata = 32'h0;
    @(negedge clk);
    chk("pre-reset busy stb", 32'(stb_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset stb_o", 32'(stb_o), 32'd0);
    chk("async reset addr_o", addr_o, 32'h0);
    chk("async reset ins_data", ins_data, 32'h0);
    data_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ins_data = 32'h0; model_data_data = 32'h0;
    chk("post reset data_ack", 32'(data_ack), 32'd0);

    r = '{1'b1, 32'h700, 1'b1, 4'hF, 1'b1, 32'h800, 3'b000, 32'h0F0F_0F0F, 1, 32'h0, 1'b0,
          1'b1, 4'hF, 1'b1, 32'h800, 3'b000, 32'h0F0F_0F0F};
    run_vec(r, "rst0");
    r = '{1'b1, 32'h700, 1'b0, 4'h0, 1'b0, 32'h0, 3'b000, 32'h0, 1, 32'h0000_00AB, 1'b0,
          1'b0, 4'hF, 1'b0, 32'h700, 3'b000, 32'h0};
    run_vec(r, "rst1");

    repeat (2) @(negedge clk);
    chk("total ins acks", 32'(ins_ack_cnt), 32'd8);
    chk("total data acks", 32'(data_ack_cnt), 32'd8);
    chk("fixed prio ins grants", 32'(fp_ins_cnt), 32'd0);
    chk("fixed prio data grants >= 20", 32'(fp_data_cnt >= 20), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that sits directly upstream of the RAM bus and shares its single request/ack channel between the instruction-fetch port and the data (load/store/atomic) port. Each transaction is latched into registered outputs and held until the RAM bus acks. The response is then routed back to the winning port. The arbiter keeps the data port's grant across an AMO lock/unlock pair, so an atomic read-modify-write cannot interleave with instruction fetches.

## Interface
- `RR_ENABLE`, default 1: 1 = round-robin between ports on simultaneous requests; 0 = fixed priority, data port wins.
- `clk_i`  in  1  system clock, all state on rising edge.
- `rst_n_i`  in  1  reset, asynchronous and active-low.
- `ins_stb_i`  in  1  instruction-port request, level, held until `ins_ack_o`.
- `ins_addr_i`  in  32  instruction byte address. Instruction requests are always 32-bit reads: `sel` is 4'b1111, `we` is 0, tag is 3'b000.
- `ins_ack_o`  out  1  one-cycle completion pulse.
- `ins_data_o`  out  32  read data, valid with `ins_ack_o`.
- `data_stb_i`  in  1  data-port request, level, held until `data_ack_o`.
- `data_sel_i`  in  4  byte select (4'b0001 byte, 4'b0011 half, 4'b1111 word).
- `data_we_i`  in  1  write enable.
- `data_addr_i`  in  32  byte address.
- `data_addr_tag_i`  in  3  atomic tag: [2:1] mode (NONE/LRSC/AMO), [0] LOCK/UNLOCK.
- `data_data_i`  in  32  write data.
- `data_ack_o`  out  1  one-cycle completion pulse.
- `data_data_o`  out  32  read data, valid with `data_ack_o`.
- `data_data_tag_o`  out  1  sc.w failure flag from the RAM bus, valid with `data_ack_o`.
- `stb_o`, `sel_o`[4], `we_o`, `addr_o`[32], `addr_tag_o`[3], `data_o`[32]  out  request to the RAM bus, all registered.
- `ack_i`  in  1  RAM bus completion.
- `data_i`  in  32  RAM bus read data.
- `data_tag_i`  in  1  RAM bus data tag.

## Operation
- FSM states: IDLE, BUSY_INS, BUSY_DATA.
- IDLE:
  - If either stb is high, choose a winner:
    - If `amo_lock` is set, only the data port is eligible.
    - Otherwise, with both ports requesting and `RR_ENABLE`=1, the port not served last (`last_grant`) wins.
    - With `RR_ENABLE`=0, the data port wins.
    - With a single requester, that port wins.
  - Latch the winner's fields into the output registers and set `stb_o`=1.
  - Go to BUSY_INS or BUSY_DATA.
- BUSY_x:
  - Output registers stay frozen; later changes on port inputs are ignored.
  - On `ack_i`:
    - `stb_o`<=0.
    - Register `data_i`/`data_tag_i` into the winner's response outputs and pulse the winner's ack for one cycle.
    - Update `last_grant`, go to IDLE.
- `amo_lock`:
  - Set when a data transaction with tag mode AMO, tag[0]=LOCK, `we`=0 completes.
  - Cleared when a data transaction with mode AMO, tag[0]=UNLOCK, `we`=1 completes.
  - While set, the instruction port is stalled indefinitely.
  - LRSC and NONE tags do not affect the lock; LR/SC reservation checking is owned by the RAM bus.
- Port protocol:
  - A master drops stb, or presents a new request, in the cycle its ack is high.
  - The arbiter does not sample in the ack cycle, because it is in IDLE only from the following cycle.
- The instruction port ignores tag and write data. The arbiter drives fixed values for those fields.
- Response data for the non-winning port holds its previous value.

## Timing
- Reset values: `stb_o`=0, `sel_o`=0, `we_o`=0, `addr_o`=0, `addr_tag_o`=0, `data_o`=0.
- Reset values, continued: both acks 0, both response data 0, `data_data_tag_o`=0, `amo_lock`=0, `last_grant`=INS, state IDLE.
- Request latency: port stb high and sampled at edge N gives `stb_o`=1 after edge N.
- Response latency: `ack_i` high at edge M gives port ack and data after edge M, and `stb_o`=0 after edge M.
- Minimum turnaround: with a zero-wait RAM bus (`ack_i` at N+1), the port ack is asserted in cycle N+1→N+2. The next arbitration happens at edge N+2.
- Simultaneous requests at the same edge: exactly one grant. The loser stays pending and wins next, unless it is the instruction port and an AMO lock was just taken.
- `ack_i` while IDLE is ignored: no port ack, no state change.
- Reset asserted mid-transaction clears state immediately. The pending port never receives an ack and must reissue.

## Test plan
- Single instruction read at 0x0000_0100 with the RAM returning 0xDEAD_BEEF after 3 cycles → `stb_o` held for 3 cycles, `sel_o`=4'b1111, `we_o`=0. One `ins_ack_o` pulse with `ins_data_o`=0xDEAD_BEEF; `data_ack_o` never pulses.
- Data byte write, sel 0001, addr 0x0000_0203, data 0x0000_00A5 → RAM request shows the identical fields. One `data_ack_o` pulse; the instruction port is untouched.
- Both ports request continuously, `RR_ENABLE`=1 → grants alternate DATA, INS, DATA, INS (after reset `last_grant`=INS). With `RR_ENABLE`=0 → every grant goes to the data port.
- AMO sequence: data lock read at 0x400 (tag AMO/LOCK), then two idle cycles, then unlock write at 0x400, with the instruction port requesting throughout → no instruction grant between the two data transactions. The instruction grant comes right after the unlock ack.
- sc.w failure: the RAM returns `data_tag_i`=1 → `data_data_tag_o`=1 with `data_ack_o`, and `amo_lock` stays 0.
- `rst_n_i` low for one cycle while BUSY_DATA → `stb_o` and acks go to 0 asynchronously. After release, a new instruction request is served normally.
